// File: rtl/fetch_ctrl_pkg.sv
// Shared constants, state encoding and PC helpers for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_0000_0000;
  localparam logic [XLEN-1:0]   INST_INC = 64'd4;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  // Binary-encoded sequencer states
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'b00,
    FETCH_FETCH = 2'b01,
    FETCH_HOLD  = 2'b10,
    FETCH_DROP  = 2'b11
  } fetch_state_e;

  // Redirect targets are word aligned: the two low bits are forced to zero
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge port of the fetch sequencer.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic              imem_req_o;
  logic [XLEN-1:0]   imem_addr_o;
  logic              imem_ack_i;
  logic [INST_W-1:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );

endinterface

// File: rtl/fetch_ctrl_buf.sv
// One-entry skid buffer that parks a fetched word while the ID stage is stalled.
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic [XLEN-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_valid
);

  logic [XLEN-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;

  // Capture the word on load, drop it on clear, otherwise hold it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_valid <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs one outstanding imem
// transaction and feeds the IF/ID register, honouring stalls and redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  fetch_ctrl_if.master      imem,
  output logic              ce_o,
  output logic [XLEN-1:0]   if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_tgt;
  logic [XLEN-1:0]   w_next_pc;
  logic [XLEN-1:0]   w_next_tgt;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_pc_inc;
  logic              w_buf_load;
  logic              w_buf_clear;
  logic [XLEN-1:0]   w_buf_pc;
  logic [INST_W-1:0] w_buf_inst;
  logic              w_buf_valid;
  logic              w_req;
  logic              w_ce;
  logic              w_we;
  logic              w_flush;
  logic [XLEN-1:0]   w_if_pc;
  logic [INST_W-1:0] w_if_inst;

  assign w_target = align_pc(redirect_pc_i);
  assign w_pc_inc = r_pc + INST_INC;  // wraps silently at 2^XLEN

  fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_pc),
    .i_inst  (imem.imem_data_i),
    .o_pc    (w_buf_pc),
    .o_inst  (w_buf_inst),
    .o_valid (w_buf_valid)
  );

  // State, fetch PC and pending redirect target registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= FETCH_IDLE;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_tgt   <= w_next_tgt;
    end
  end

  // Next-state, PC update and IF/ID strobes; redirect outranks ack, ack outranks stall
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_tgt   = r_tgt;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    w_req        = 1'b0;
    w_ce         = 1'b0;
    w_we         = 1'b0;
    w_flush      = 1'b0;
    w_if_pc      = 64'h0;
    w_if_inst    = 32'h0;
    case (r_state)
      FETCH_IDLE: begin
        w_next_state = FETCH_FETCH;
      end
      FETCH_FETCH: begin
        w_ce    = 1'b1;
        w_req   = 1'b1;
        w_flush = redirect_i;
        if (redirect_i) begin
          w_if_inst = INST_NOP;
          if (imem.imem_ack_i) begin
            w_next_pc = w_target;
          end else begin
            // Request must stay stable until its ack, so park the target
            w_next_tgt   = w_target;
            w_next_state = FETCH_DROP;
          end
        end else if (imem.imem_ack_i) begin
          w_next_pc = w_pc_inc;
          if (stall_i) begin
            w_buf_load   = 1'b1;
            w_next_state = FETCH_HOLD;
          end else begin
            w_we      = 1'b1;
            w_if_pc   = r_pc;
            w_if_inst = imem.imem_data_i;
          end
        end else begin
          w_next_state = FETCH_FETCH;
        end
      end
      FETCH_HOLD: begin
        w_ce      = 1'b1;
        w_flush   = redirect_i;
        w_if_pc   = w_buf_pc;
        w_if_inst = w_buf_inst;
        if (redirect_i) begin
          w_buf_clear  = 1'b1;
          w_next_pc    = w_target;
          w_next_state = FETCH_FETCH;
        end else if (!stall_i) begin
          w_we         = w_buf_valid;
          w_buf_clear  = 1'b1;
          w_next_state = FETCH_FETCH;
        end else begin
          w_next_state = FETCH_HOLD;
        end
      end
      FETCH_DROP: begin
        w_ce      = 1'b1;
        w_req     = 1'b1;
        w_flush   = redirect_i;
        w_if_inst = INST_NOP;
        if (redirect_i) begin
          // Latest redirect wins over any earlier pending target
          if (imem.imem_ack_i) begin
            w_next_pc    = w_target;
            w_next_state = FETCH_FETCH;
          end else begin
            w_next_tgt = w_target;
          end
        end else if (imem.imem_ack_i) begin
          w_next_pc    = r_tgt;
          w_next_state = FETCH_FETCH;
        end else begin
          w_next_state = FETCH_DROP;
        end
      end
      default: begin
        w_next_state = FETCH_IDLE;
      end
    endcase
  end

  // Reset has top priority: while it is asserted every strobe is forced low
  always_comb begin
    if (rst) begin
      imem.imem_req_o = w_req;
      ce_o            = w_ce;
      ifid_we_o       = w_we;
      ifid_flush_o    = w_flush;
      if_pc_o         = w_if_pc;
      if_inst_o       = w_if_inst;
    end else begin
      imem.imem_req_o = 1'b0;
      ce_o            = 1'b0;
      ifid_we_o       = 1'b0;
      ifid_flush_o    = 1'b0;
      if_pc_o         = 64'h0;
      if_inst_o       = 32'h0;
    end
  end

  assign imem.imem_addr_o = r_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        ce_o;
  logic [63:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        ifid_we_o;
  logic        ifid_flush_o;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus),
    .ce_o          (ce_o),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o),
    .ifid_we_o     (ifid_we_o),
    .ifid_flush_o  (ifid_flush_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: what the sequencer must be doing, as plain flags
  bit          m_known = 1'b0;  // a reset edge has been seen
  bit          m_boot;          // the single dead cycle after reset
  bit          m_held;          // a word is parked waiting for ID
  bit          m_drop;          // outstanding fetch will be thrown away
  logic [63:0] m_pc;
  logic [63:0] m_tgt;
  logic [63:0] m_bpc;
  logic [31:0] m_binst;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_req(input logic r);
    return r && !m_boot && !m_held;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check, advance model
  task automatic step(input logic r, input logic st, input logic rd,
                      input logic [63:0] rp, input logic ak, input logic [31:0] dt);
    bit          e_ce, e_req, e_we, e_fl, e_show;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    @(negedge clk);
    rst             = r;
    stall_i         = st;
    redirect_i      = rd;
    redirect_pc_i   = rp;
    bus.imem_ack_i  = ak;
    bus.imem_data_i = dt;
    #1;
    e_ce = 1'b0; e_req = 1'b0; e_we = 1'b0; e_fl = 1'b0; e_show = 1'b0;
    e_pc = 64'h0; e_inst = 32'h0;
    if (r && !m_boot) begin
      e_ce  = 1'b1;
      e_fl  = rd;
      e_req = !m_held;
      if (m_held) begin
        e_show = 1'b1;
        e_pc   = m_bpc;
        e_inst = m_binst;
        e_we   = !rd && !st;
      end else if (ak && !rd && !m_drop && !st) begin
        e_show = 1'b1;
        e_we   = 1'b1;
        e_pc   = m_pc;
        e_inst = dt;
      end
    end
    if (m_known) begin
      chk("ce", ce_o, e_ce);
      chk("req", bus.imem_req_o, e_req);
      chk("we", ifid_we_o, e_we);
      chk("flush", ifid_flush_o, e_fl);
      if (e_req) chk("addr", bus.imem_addr_o, m_pc);
      if (e_show) begin
        chk("if_pc", if_pc_o, e_pc);
        chk("if_inst", if_inst_o, e_inst);
      end
    end
    if (!r) begin
      m_known = 1'b1; m_boot = 1'b1; m_held = 1'b0; m_drop = 1'b0;
      m_pc = 64'h0; m_tgt = 64'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_held) begin
      if (rd) begin
        m_held = 1'b0;
        m_pc   = {rp[63:2], 2'b00};
      end else if (!st) begin
        m_held = 1'b0;
      end
    end else if (rd) begin
      if (ak) begin
        m_pc   = {rp[63:2], 2'b00};
        m_drop = 1'b0;
      end else begin
        m_drop = 1'b1;
        m_tgt  = {rp[63:2], 2'b00};
      end
    end else if (ak) begin
      if (m_drop) begin
        m_pc   = m_tgt;
        m_drop = 1'b0;
      end else begin
        if (st) begin
          m_held  = 1'b1;
          m_bpc   = m_pc;
          m_binst = dt;
        end
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  initial begin
    int          mem_wait;
    bit          r, st, rd, ak;
    logic [63:0] rp;
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 64'h0;
    bus.imem_ack_i = 1'b0; bus.imem_data_i = 32'h0;

    // Reset
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("rst_req", bus.imem_req_o, 64'h0);
    chk("rst_ce", ce_o, 64'h0);
    chk("rst_addr", bus.imem_addr_o, 64'h0);

    // Zero-wait streaming, then a stall at pc=8
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("c1_ce", ce_o, 64'h0);
    chk("c1_req", bus.imem_req_o, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'hA000_0000);
    chk("c2_req", bus.imem_req_o, 64'h1);
    chk("c2_addr", bus.imem_addr_o, 64'h0);
    chk("c2_we", ifid_we_o, 64'h1);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'hA000_0004);
    chk("c3_addr", bus.imem_addr_o, 64'h4);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 32'hA000_0008);
    chk("stall_addr", bus.imem_addr_o, 64'h8);
    chk("stall_we", ifid_we_o, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("hold_req", bus.imem_req_o, 64'h0);
    chk("hold_pc", if_pc_o, 64'h8);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("hold_we", ifid_we_o, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("release_we", ifid_we_o, 64'h1);
    chk("release_inst", if_inst_o, 64'hA000_0008);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'hA000_000C);
    chk("after_hold_addr", bus.imem_addr_o, 64'hC);

    // Redirect while the ack is still pending
    step(1'b1, 1'b0, 1'b1, 64'h1002, 1'b0, 32'h0);
    chk("redir_flush", ifid_flush_o, 64'h1);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("drop_addr", bus.imem_addr_o, 64'h10);
    chk("drop_flush", ifid_flush_o, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF);
    chk("drop_ack_we", ifid_we_o, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'hB000_1000);
    chk("redir_addr", bus.imem_addr_o, 64'h1000);

    // Redirect and ack together
    step(1'b1, 1'b0, 1'b1, 64'h2000, 1'b1, 32'h1111_1111);
    chk("ra_we", ifid_we_o, 64'h0);
    chk("ra_flush", ifid_flush_o, 64'h1);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("ra_addr", bus.imem_addr_o, 64'h2000);

    // PC wrap at the top of the address space
    step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'hC0DE_0001);
    chk("top_addr", bus.imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("model_wrap", m_pc, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("wrap_addr", bus.imem_addr_o, 64'h0);

    // Reset in DROP with an ack arriving, then a late ack
    step(1'b1, 1'b0, 1'b1, 64'h3000, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h2222_2222);
    chk("rdrop_req", bus.imem_req_o, 64'h0);
    chk("rdrop_we", ifid_we_o, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h3333_3333);
    chk("late_we", ifid_we_o, 64'h0);
    chk("late_addr", bus.imem_addr_o, 64'h0);
    chk("model_restart", m_pc, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("restart_req", bus.imem_req_o, 64'h1);
    chk("restart_addr", bus.imem_addr_o, 64'h0);

    // Randomized traffic with a variable-latency memory
    mem_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(199) != 0);
      st = ($urandom_range(9) < 3);
      rd = ($urandom_range(19) == 0);
      rp = {$urandom, $urandom};
      if (model_req(r)) begin
        ak = (mem_wait == 0);
        if (ak) mem_wait = $urandom_range(2);
        else    mem_wait = mem_wait - 1;
      end else begin
        ak = ($urandom_range(31) == 0);
      end
      step(r, st, rd, rp, ak, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
